// File: rtl/bc_pkg.sv
// Shared constants for the instruction timing FSM: state codes, phase codes, field widths.
// Latency: n/a. Backpressure: n/a.
package bc_pkg;

    localparam int SEQ_W   = 4;
    localparam int NUM_T   = 1 << SEQ_W;
    localparam int OPC_W   = 3;
    localparam int NUM_D   = 1 << OPC_W;
    localparam int IR_W    = 16;
    localparam int I_POS   = 15;
    localparam int OPC_LSB = 12;
    localparam int HLT_BIT = 0;

    localparam logic [OPC_W-1:0] HLT_OPC = 3'd7;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_HALT   = 3'd4;

    localparam logic [2:0] PH_NONE   = 3'b000;
    localparam logic [2:0] PH_FETCH  = 3'b001;
    localparam logic [2:0] PH_DECODE = 3'b010;
    localparam logic [2:0] PH_EXEC   = 3'b100;

    localparam logic [SEQ_W-1:0] SEQ_FETCH_LAST = 4'd1;
    localparam logic [SEQ_W-1:0] SEQ_HLT        = 4'd3;
    localparam logic [SEQ_W-1:0] SEQ_MAX        = 4'd15;

    function automatic logic [NUM_D-1:0] opc_onehot(input logic [OPC_W-1:0] opc);
        return NUM_D'(1) << opc;
    endfunction

endpackage

// File: rtl/decoder_4to16.sv
// Enabled 4-to-16 one-hot decoder producing the T0..T15 timing strobes.
// Latency: combinational. Backpressure: none.
module decoder_4to16
    import bc_pkg::*;
(
    input  logic             en,
    input  logic [SEQ_W-1:0] sel,
    output logic [NUM_T-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/timing_control.sv
// Instruction timing FSM (IDLE/FETCH/DECODE/EXEC/HALT) commanding the sequence counter; TC_WATCHDOG_EN adds an execute watchdog.
// Latency: sc_inc/sc_clr/t/phase combinational from state; d, i_bit, err registered at the next edge.
// Backpressure: none; the done strobe is the only execute-phase handshake.
module timing_control
    import bc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEQ_W-1:0] sequence_cnt,
    input  logic [IR_W-1:0]  ir_in,
    input  logic             done,
    output logic             sc_inc,
    output logic             sc_clr,
    output logic [NUM_T-1:0] t,
    output logic [NUM_D-1:0] d,
    output logic             i_bit,
    output logic [2:0]       phase,
    output logic             err
);

    state_t state;
    state_t next_state;
    logic   load_dec;
    logic   hlt_hit;
    logic   t_en;
    logic   unused_ir;

    // Only I, opcode and the HLT reg-ref bit matter to timing; the rest belongs to the datapath.
    assign unused_ir = ^ir_in[11:1];

    // HLT is recognised from the latched decode plus the live reg-ref bit.
    assign hlt_hit = (sequence_cnt == SEQ_HLT) && d[HLT_OPC] && !i_bit && ir_in[HLT_BIT];

`ifdef TC_WATCHDOG_EN
    logic wd_trip;
    logic err_q;
`endif

    always_comb begin
        next_state = state;
        sc_inc     = 1'b0;
        sc_clr     = 1'b0;
        load_dec   = 1'b0;
`ifdef TC_WATCHDOG_EN
        wd_trip    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                sc_clr = 1'b1;
                if (start) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                sc_inc = 1'b1;
                if (sequence_cnt == SEQ_FETCH_LAST) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                sc_inc     = 1'b1;
                load_dec   = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                // HLT beats done; done beats the watchdog.
                if (hlt_hit) begin
                    sc_clr     = 1'b1;
                    next_state = ST_HALT;
                end else if (done) begin
                    sc_clr     = 1'b1;
                    next_state = ST_FETCH;
                end
`ifdef TC_WATCHDOG_EN
                else if (sequence_cnt == SEQ_MAX) begin
                    sc_clr     = 1'b1;
                    wd_trip    = 1'b1;
                    next_state = ST_FETCH;
                end
`endif
                else begin
                    sc_inc = 1'b1;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                sc_clr     = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            d     <= '0;
            i_bit <= 1'b0;
        end else begin
            state <= next_state;
            if (load_dec) begin
                d     <= opc_onehot(ir_in[OPC_LSB +: OPC_W]);
                i_bit <= ir_in[I_POS];
            end
        end
    end

`ifdef TC_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (wd_trip) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        case (state)
            ST_FETCH:  phase = PH_FETCH;
            ST_DECODE: phase = PH_DECODE;
            ST_EXEC:   phase = PH_EXEC;
            default:   phase = PH_NONE;
        endcase
    end

    assign t_en = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);

    decoder_4to16 u_tdec (
        .en  (t_en),
        .sel (sequence_cnt),
        .y   (t)
    );

endmodule

// File: tb/tb_timing_control.sv
// Self-checking bench for timing_control with a behavioural sequence counter closing the loop.
// Table rows are queued as expectations when driven and compared when sampled on the falling edge.
module tb_timing_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [15:0] ir_in;
    logic [3:0]  seq;
    logic        sc_inc;
    logic        sc_clr;
    logic [15:0] t;
    logic [7:0]  d;
    logic        i_bit;
    logic [2:0]  phase;
    logic        err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Sequence counter driven by the DUT's commands.
    always @(posedge clk) begin
        if (sc_clr) seq <= 4'd0;
        else if (sc_inc) seq <= seq + 4'd1;
    end

    timing_control dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sequence_cnt (seq),
        .ir_in        (ir_in),
        .done         (done),
        .sc_inc       (sc_inc),
        .sc_clr       (sc_clr),
        .t            (t),
        .d            (d),
        .i_bit        (i_bit),
        .phase        (phase),
        .err          (err)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        done;
        logic [15:0] ir;
        logic [3:0]  seq;
        logic [15:0] t;
        logic [2:0]  ph;
        logic        inc;
        logic        clr;
        logic [7:0]  d;
        logic        ib;
        logic        err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    vec_t exp_q [$];
    vec_t e;
    bit   ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic cmp_row(input int i, input vec_t x);
        chk($sformatf("row%0d.seq", i),    {28'd0, seq},    {28'd0, x.seq});
        chk($sformatf("row%0d.t", i),      {16'd0, t},      {16'd0, x.t});
        chk($sformatf("row%0d.phase", i),  {29'd0, phase},  {29'd0, x.ph});
        chk($sformatf("row%0d.sc_inc", i), {31'd0, sc_inc}, {31'd0, x.inc});
        chk($sformatf("row%0d.sc_clr", i), {31'd0, sc_clr}, {31'd0, x.clr});
        chk($sformatf("row%0d.d", i),      {24'd0, d},      {24'd0, x.d});
        chk($sformatf("row%0d.i_bit", i),  {31'd0, i_bit},  {31'd0, x.ib});
        chk($sformatf("row%0d.err", i),    {31'd0, err},    {31'd0, x.err});
    endtask

    // Returns at the falling edge where EXEC is seen at sequence tgt, or after a bounded wait.
    task automatic wait_exec(input logic [3:0] tgt, output bit found);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (phase == 3'b100 && seq == tgt) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //           rst   start done  ir        seq    t         ph      inc   clr   d      ib    err
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 3'b000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 16'h0000, 3'b000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0001, 3'b001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'd1, 16'h0002, 3'b001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h2ABC, 4'd2, 16'h0004, 3'b010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'd3, 16'h0008, 3'b100, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'd4, 16'h0010, 3'b100, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'd5, 16'h0020, 3'b100, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0001, 3'b001, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'd1, 16'h0002, 3'b001, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'hF001, 4'd2, 16'h0004, 3'b010, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'hF001, 4'd3, 16'h0008, 3'b100, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 16'hF001, 4'd4, 16'h0010, 3'b100, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'hF001, 4'd0, 16'h0001, 3'b001, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h7001, 4'd1, 16'h0002, 3'b001, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h7001, 4'd2, 16'h0004, 3'b010, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 16'h7001, 4'd3, 16'h0008, 3'b100, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h7001, 4'd0, 16'h0000, 3'b000, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        done  = 1'b0;
        ir_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rst   = vecs[i].rst;
            start = vecs[i].start;
            done  = vecs[i].done;
            ir_in = vecs[i].ir;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            cmp_row(i, e);
            @(posedge clk);
            #1;
        end

        // HALT must hold for 20 cycles regardless of start/done.
        for (int k = 0; k < 20; k++) begin
            start = 1'b1;
            done  = 1'b1;
            @(negedge clk);
            chk($sformatf("halt%0d.seq", k),    {28'd0, seq},    32'd0);
            chk($sformatf("halt%0d.t", k),      {16'd0, t},      32'd0);
            chk($sformatf("halt%0d.sc_inc", k), {31'd0, sc_inc}, 32'd0);
            chk($sformatf("halt%0d.sc_clr", k), {31'd0, sc_clr}, 32'd0);
            chk($sformatf("halt%0d.phase", k),  {29'd0, phase},  32'd0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        done  = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("halt_rst.sc_clr", {31'd0, sc_clr}, 32'd1);
        chk("halt_rst.sc_inc", {31'd0, sc_inc}, 32'd0);
        chk("halt_rst.phase",  {29'd0, phase},  32'd0);
        chk("halt_rst.d",      {24'd0, d},      32'd0);
        chk("halt_rst.t",      {16'd0, t},      32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of an execute phase.
        start = 1'b1;
        ir_in = 16'h3000;
        wait_exec(4'd7, ok);
        start = 1'b0;
        chk("mid_exec.reached", {31'd0, ok}, 32'd1);
        chk("mid_exec.d",       {24'd0, d},  32'h08);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst.phase",  {29'd0, phase},  32'd0);
        chk("mid_rst.sc_clr", {31'd0, sc_clr}, 32'd1);
        chk("mid_rst.sc_inc", {31'd0, sc_inc}, 32'd0);
        chk("mid_rst.d",      {24'd0, d},      32'd0);
        chk("mid_rst.i_bit",  {31'd0, i_bit},  32'd0);
        chk("mid_rst.err",    {31'd0, err},    32'd0);
        chk("mid_rst.t",      {16'd0, t},      32'd0);
        @(posedge clk);
        #1;

        // done at the last count terminates normally without an error.
        start = 1'b1;
        ir_in = 16'h1000;
        wait_exec(4'd15, ok);
        start = 1'b0;
        chk("seq15.reached", {31'd0, ok}, 32'd1);
        chk("seq15.d",       {24'd0, d},  32'h02);
        done = 1'b1;
        #1;
        chk("seq15_done.sc_clr", {31'd0, sc_clr}, 32'd1);
        chk("seq15_done.sc_inc", {31'd0, sc_inc}, 32'd0);
        @(posedge clk);
        #1;
        done = 1'b0;
        @(negedge clk);
        chk("after_done.phase", {29'd0, phase}, 32'b001);
        chk("after_done.seq",   {28'd0, seq},   32'd0);
        chk("after_done.err",   {31'd0, err},   32'd0);

        // No done: watchdog trips, or the counter wraps when it is compiled out.
        wait_exec(4'd15, ok);
        chk("wd.reached", {31'd0, ok}, 32'd1);
`ifdef TC_WATCHDOG_EN
        chk("wd.sc_clr", {31'd0, sc_clr}, 32'd1);
        chk("wd.sc_inc", {31'd0, sc_inc}, 32'd0);
`else
        chk("wrap.sc_clr", {31'd0, sc_clr}, 32'd0);
        chk("wrap.sc_inc", {31'd0, sc_inc}, 32'd1);
`endif
        chk("wd.err_before", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wd_next.seq", {28'd0, seq}, 32'd0);
`ifdef TC_WATCHDOG_EN
        chk("wd_next.phase", {29'd0, phase}, 32'b001);
        chk("wd_next.err",   {31'd0, err},   32'd1);
`else
        chk("wrap_next.phase", {29'd0, phase}, 32'b100);
        chk("wrap_next.err",   {31'd0, err},   32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
`ifdef TC_WATCHDOG_EN
        chk("wd_sticky.err", {31'd0, err}, 32'd1);
`else
        chk("wrap_later.err", {31'd0, err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timing_control.md
TIMING_CONTROL -- requirements
Module: timing_control

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: start  input  1  run request; sampled only in IDLE.
REQ-004 SHALL have port: sequence  input  4  current count from sequencecounter.
REQ-005 SHALL have port: ir_in  input  16  instruction register contents: [15]=I, [14:12]=opcode, [11:0]=address/reg-ref bits.
REQ-006 SHALL have port: done  input  1  execute-phase completion strobe from the execution datapath.
REQ-007 SHALL have port: sc_inc  output  1  increment command to sequencecounter.
REQ-008 SHALL have port: sc_clr  output  1  clear command to sequencecounter.
REQ-009 SHALL have port: t  output  16  one-hot timing signals T0..T15.
REQ-010 SHALL have port: d  output  8  latched one-hot opcode D0..D7.
REQ-011 SHALL have port: i_bit  output  1  latched indirect bit.
REQ-012 SHALL have port: phase  output  3  one-hot FSM state: fetch, decode, execute.
REQ-013 SHALL have port: err  output  1  sticky watchdog error flag.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-015 IDLE: sc_clr=1, sc_inc=0; start=1 -> FETCH next cycle, so sequence=0 on entry to FETCH.
REQ-016 FETCH: sc_inc=1, sc_clr=0; sequence==1 -> DECODE next.
REQ-017 DECODE (sequence==2): d <= one-hot(ir_in[14:12]), i_bit <= ir_in[15]; sc_inc=1; -> EXEC next.
REQ-018 EXEC: sc_inc=1 unless terminating; done=1 -> sc_clr=1, sc_inc=0, -> FETCH next (new instruction starts at T0).
REQ-019 EXEC at sequence==3 with latched HLT (d[7]=1, i_bit=0, ir_in[0]=1) -> sc_clr=1, -> HALT; done ignored that cycle.
REQ-020 HALT: sc_inc=0, sc_clr=0, sequence frozen; exit only via rst.
REQ-021 sc_inc and sc_clr SHALL never both be 1; decoded combinationally from state, sequence and done (zero latency into sequencecounter's next edge).
REQ-022 t SHALL be one-hot(sequence) in FETCH/DECODE/EXEC and all-zero in IDLE and HALT.
REQ-023 d and i_bit SHALL hold their values outside DECODE.
REQ-024 phase SHALL be 3'b000 in IDLE and HALT.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 done outside EXEC SHALL be ignored.

Reset
REQ-027 rst=1 SHALL force IDLE, d=0, i_bit=0, err=0, t=0, phase=0, sc_clr=1, sc_inc=0 on the next rising edge, regardless of state (including mid-EXEC and HALT).
REQ-028 rst SHALL take priority over start, done and watchdog.

Configuration
REQ-029 Macro TC_WATCHDOG_EN SHALL compile in the execute watchdog.
REQ-030 With TC_WATCHDOG_EN: EXEC with sequence==15 and done=0 -> err <= 1 (sticky), sc_clr=1, -> FETCH; done=1 at sequence==15 wins, err unchanged.
REQ-031 Without TC_WATCHDOG_EN: err tied 0; EXEC keeps sc_inc=1, sequence wraps 15->0, state stays EXEC until done.

Structure
REQ-032 Shared package bc_pkg SHALL hold the state enum, opcode width (3), HLT opcode (3'd7), HLT bit index (0), sequence width (4).
REQ-033 Sub-module decoder_4to16 SHALL produce t; the 3-to-8 opcode decode is inline.

Verification
REQ-034 rst then start=1 -> sequence 0,1,2,3; t=0x0001,0x0002,0x0004,0x0008; phase fetch,fetch,decode,execute.
REQ-035 ir_in=0x2ABC at T2 -> d=0x04, i_bit=0 from next cycle; ir_in changed later -> d unchanged.
REQ-036 done=1 at sequence==5 -> sc_clr=1 that cycle, sequence=0, phase=fetch next.
REQ-037 ir_in=0x7001 -> at T3 sc_clr=1; then sequence=0, t=0, sc_inc=0 for 20 cycles; rst -> IDLE.
REQ-038 TC_WATCHDOG_EN, done never asserted -> at sequence==15 err=1, sequence=0 next; without macro sequence wraps, err=0.
REQ-039 rst=1 at sequence==7 in EXEC -> next cycle IDLE, sc_clr=1, d=0, err=0.
